// File: rtl/lc3_datapath_p.sv
// lc3_datapath_p: LC-3-style datapath with a memory request/ready handshake.
//
// Holds the PC/IR/MAR/MDR registers, an NREGS-entry register file, the ALU, the
// address adder and the NZP condition codes. All sources meet on one shared bus,
// selected by one-hot gate enables. A small IDLE/REQ/DONE FSM runs one memory
// access at a time. MAR and MDR are frozen while an access is in flight.
//
// Ports:
//   Clk, Reset_al                     clock (rising edge), async active-low reset
//   LD_PC/IR/MAR/MDR/REG/CC           register load enables
//   GateALU/PC/MARMUX/MDR             bus drive enables (one-hot expected)
//   PCMUX, ADDR1MUX, ADDR2MUX, SR2MUX mux selects
//   ALUK                              ALU op: ADD, AND, NOT A, PASS A
//   DR, SR1, SR2                      register-file write / read addresses
//   Mem_Start, Mem_WE                 start an access (write when Mem_WE=1)
//   Mem_Rdy, Mem_RData                memory completion strobe and read data
//   Mem_Req, Mem_Wr, Mem_Addr,
//   Mem_WData, Mem_Busy, Mem_Done     memory-side handshake outputs
//   IR, PC, MAR, MDR, NZP             architectural state
//   Bus_Err                           sticky flag: bus contention seen
module lc3_datapath_p #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREGS    = 8,
  parameter logic [15:0] RESET_PC = 16'h0,
  localparam int unsigned RW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             Clk,
  input  logic             Reset_al,
  input  logic             LD_PC,
  input  logic             LD_IR,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic             GateALU,
  input  logic             GatePC,
  input  logic             GateMARMUX,
  input  logic             GateMDR,
  input  logic [1:0]       PCMUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic             SR2MUX,
  input  logic [1:0]       ALUK,
  input  logic [RW-1:0]    DR,
  input  logic [RW-1:0]    SR1,
  input  logic [RW-1:0]    SR2,
  input  logic             Mem_Start,
  input  logic             Mem_WE,
  input  logic             Mem_Rdy,
  input  logic [WIDTH-1:0] Mem_RData,
  output logic             Mem_Req,
  output logic             Mem_Wr,
  output logic [WIDTH-1:0] Mem_Addr,
  output logic [WIDTH-1:0] Mem_WData,
  output logic             Mem_Busy,
  output logic             Mem_Done,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [2:0]       NZP,
  output logic             Bus_Err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} mem_st_e;

  // NREGS widened by one bit so the range check also works for power-of-2 sizes.
  localparam logic [RW:0] NRegsW = (RW + 1)'(NREGS);
  localparam logic [WIDTH-1:0] One = {{(WIDTH - 1){1'b0}}, 1'b1};

  mem_st_e          mem_st_q, mem_st_d;
  logic             mem_wr_q, mem_wr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [2:0]       nzp_q, nzp_d;
  logic             bus_err_q;
  logic [WIDTH-1:0] regs_q [NREGS];

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] sr1_out, sr2_out;
  logic [WIDTH-1:0] alu_b, alu_out;
  logic [WIDTH-1:0] addr1, addr2, adder_out;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] imm5, off6, off9, off11;
  logic [3:0]       gates;
  logic             multi_gate;
  logic             sr1_ok, sr2_ok, dr_ok;
  logic             mem_busy;
  logic             rd_complete;

  // Sign-extended IR fields
  assign imm5  = {{(WIDTH - 5){ir_q[4]}},   ir_q[4:0]};
  assign off6  = {{(WIDTH - 6){ir_q[5]}},   ir_q[5:0]};
  assign off9  = {{(WIDTH - 9){ir_q[8]}},   ir_q[8:0]};
  assign off11 = {{(WIDTH - 11){ir_q[10]}}, ir_q[10:0]};

  // Register-file reads are combinational; out-of-range addresses read as zero.
  assign sr1_ok  = {1'b0, SR1} < NRegsW;
  assign sr2_ok  = {1'b0, SR2} < NRegsW;
  assign dr_ok   = {1'b0, DR}  < NRegsW;
  assign sr1_out = sr1_ok ? regs_q[SR1] : '0;
  assign sr2_out = sr2_ok ? regs_q[SR2] : '0;

  // ALU
  assign alu_b = SR2MUX ? imm5 : sr2_out;
  always_comb begin
    alu_out = '0;
    case (ALUK)
      2'b00:   alu_out = sr1_out + alu_b;
      2'b01:   alu_out = sr1_out & alu_b;
      2'b10:   alu_out = ~sr1_out;
      default: alu_out = sr1_out;
    endcase
  end

  // Address adder
  assign addr1 = ADDR1MUX ? sr1_out : pc_q;
  always_comb begin
    addr2 = '0;
    case (ADDR2MUX)
      2'b00:   addr2 = '0;
      2'b01:   addr2 = off6;
      2'b10:   addr2 = off9;
      default: addr2 = off11;
    endcase
  end
  assign adder_out = addr1 + addr2;
  assign pc_inc    = pc_q + One;

  // Bus: a lone gate drives its source; none or several drive zero.
  assign gates      = {GateALU, GatePC, GateMARMUX, GateMDR};
  assign multi_gate = (gates & (gates - 4'd1)) != 4'd0;
  always_comb begin
    bus = '0;
    unique case (gates)
      4'b1000: bus = alu_out;
      4'b0100: bus = pc_q;
      4'b0010: bus = adder_out;
      4'b0001: bus = mdr_q;
      default: bus = '0;
    endcase
  end

  // Memory handshake FSM
  assign mem_busy    = mem_st_q != StIdle;
  assign rd_complete = (mem_st_q == StReq) && Mem_Rdy && !mem_wr_q;

  always_comb begin
    mem_st_d = mem_st_q;
    mem_wr_d = mem_wr_q;
    case (mem_st_q)
      StIdle: begin
        if (Mem_Start) begin
          mem_st_d = StReq;
          mem_wr_d = Mem_WE;
        end
      end
      StReq: begin
        if (Mem_Rdy) mem_st_d = StDone;
      end
      StDone: begin
        mem_st_d = StIdle;
        mem_wr_d = 1'b0;
      end
      default: begin
        mem_st_d = StIdle;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // Architectural register next state
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    nzp_d = nzp_q;

    if (LD_PC) begin
      case (PCMUX)
        2'b00:   pc_d = pc_inc;
        2'b01:   pc_d = bus;
        2'b10:   pc_d = adder_out;
        default: pc_d = pc_q;
      endcase
    end

    if (LD_IR) ir_d = bus;

    // Address and data stay frozen while an access is in flight.
    if (LD_MAR && !mem_busy) mar_d = bus;

    if (rd_complete) begin
      mdr_d = Mem_RData;
    end else if (LD_MDR && !mem_busy) begin
      mdr_d = bus;
    end

    if (LD_CC) begin
      if (bus[WIDTH-1])    nzp_d = 3'b100;
      else if (bus == '0)  nzp_d = 3'b010;
      else                 nzp_d = 3'b001;
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      mem_st_q  <= StIdle;
      mem_wr_q  <= 1'b0;
      pc_q      <= WIDTH'(RESET_PC);
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      nzp_q     <= 3'b010;
      bus_err_q <= 1'b0;
    end else begin
      mem_st_q  <= mem_st_d;
      mem_wr_q  <= mem_wr_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      nzp_q     <= nzp_d;
      bus_err_q <= bus_err_q | multi_gate;
    end
  end

  // Register file; no write bypass, so a same-cycle read sees the old value.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (LD_REG && dr_ok) begin
      regs_q[DR] <= bus;
    end
  end

  assign Mem_Req   = mem_st_q == StReq;
  assign Mem_Wr    = mem_wr_q;
  assign Mem_Addr  = mar_q;
  assign Mem_WData = mdr_q;
  assign Mem_Busy  = mem_busy;
  assign Mem_Done  = mem_st_q == StDone;
  assign IR        = ir_q;
  assign PC        = pc_q;
  assign MAR       = mar_q;
  assign MDR       = mdr_q;
  assign NZP       = nzp_q;
  assign Bus_Err   = bus_err_q;

endmodule

// File: tb/tb_lc3_datapath_p.sv
module tb_lc3_datapath_p;

  logic        Clk = 1'b0;
  logic        Reset_al;
  logic        LD_PC, LD_IR, LD_MAR, LD_MDR, LD_REG, LD_CC;
  logic        GateALU, GatePC, GateMARMUX, GateMDR;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        ADDR1MUX, SR2MUX;
  logic [2:0]  DR, SR1, SR2;
  logic        Mem_Start, Mem_WE, Mem_Rdy;
  logic [15:0] Mem_RData;
  logic        Mem_Req, Mem_Wr, Mem_Busy, Mem_Done, Bus_Err;
  logic [15:0] Mem_Addr, Mem_WData, IR, PC, MAR, MDR;
  logic [2:0]  NZP;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;
  int req_cnt = 0;
  int done_cnt = 0;

  lc3_datapath_p #(.WIDTH(16), .NREGS(8), .RESET_PC(16'h3000)) dut (
    .Clk(Clk), .Reset_al(Reset_al),
    .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .LD_REG(LD_REG), .LD_CC(LD_CC),
    .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
    .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .SR2MUX(SR2MUX),
    .ALUK(ALUK), .DR(DR), .SR1(SR1), .SR2(SR2),
    .Mem_Start(Mem_Start), .Mem_WE(Mem_WE), .Mem_Rdy(Mem_Rdy), .Mem_RData(Mem_RData),
    .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_Busy(Mem_Busy), .Mem_Done(Mem_Done),
    .IR(IR), .PC(PC), .MAR(MAR), .MDR(MDR), .NZP(NZP), .Bus_Err(Bus_Err)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  logic        m_err;
  logic        m_busy;    // an access is outstanding (request or completion phase)
  logic        m_done;    // completion phase of the access
  logic        m_wr;

  function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
    logic signed [15:0] t;
    t = $signed(v << (16 - bits));
    return 16'(t >>> (16 - bits));
  endfunction

  function automatic logic [15:0] model_bus();
    logic [15:0] a, b, alu, adder, off;
    int n;
    a = m_regs[SR1];
    b = SR2MUX ? sext(m_ir, 5) : m_regs[SR2];
    case (ALUK)
      2'd0: alu = a + b;
      2'd1: alu = a & b;
      2'd2: alu = ~a;
      default: alu = a;
    endcase
    case (ADDR2MUX)
      2'd0: off = 16'd0;
      2'd1: off = sext(m_ir, 6);
      2'd2: off = sext(m_ir, 9);
      default: off = sext(m_ir, 11);
    endcase
    adder = (ADDR1MUX ? a : m_pc) + off;
    n = int'(GateALU) + int'(GatePC) + int'(GateMARMUX) + int'(GateMDR);
    if (n != 1) return 16'd0;
    if (GateALU) return alu;
    if (GatePC) return m_pc;
    if (GateMARMUX) return adder;
    return m_mdr;
  endfunction

  always @(posedge Clk or negedge Reset_al) begin
    logic [15:0] b;
    int n;
    if (!Reset_al) begin
      m_pc <= 16'h3000; m_ir <= 0; m_mar <= 0; m_mdr <= 0; m_nzp <= 3'b010;
      m_err <= 0; m_busy <= 0; m_done <= 0; m_wr <= 0;
      for (int i = 0; i < 8; i++) m_regs[i] <= 16'd0;
    end else begin
      b = model_bus();
      n = int'(GateALU) + int'(GatePC) + int'(GateMARMUX) + int'(GateMDR);
      if (n > 1) m_err <= 1'b1;
      if (LD_PC && PCMUX == 2'd0) m_pc <= m_pc + 16'd1;
      if (LD_PC && PCMUX == 2'd1) m_pc <= b;
      if (LD_PC && PCMUX == 2'd2) m_pc <= (ADDR1MUX ? m_regs[SR1] : m_pc) +
          (ADDR2MUX == 2'd0 ? 16'd0 : ADDR2MUX == 2'd1 ? sext(m_ir, 6) :
           ADDR2MUX == 2'd2 ? sext(m_ir, 9) : sext(m_ir, 11));
      if (LD_IR) m_ir <= b;
      if (LD_REG) m_regs[DR] <= b;
      if (LD_CC) m_nzp <= b[15] ? 3'b100 : (b == 16'd0 ? 3'b010 : 3'b001);
      if (!m_busy) begin
        if (LD_MAR) m_mar <= b;
        if (LD_MDR) m_mdr <= b;
        if (Mem_Start) begin
          m_busy <= 1'b1;
          m_wr   <= Mem_WE;
        end
      end else if (m_done) begin
        m_busy <= 1'b0; m_done <= 1'b0; m_wr <= 1'b0;
      end else if (Mem_Rdy) begin
        m_done <= 1'b1;
        if (!m_wr) m_mdr <= Mem_RData;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (run_chk) begin
      chk("PC", PC, m_pc);
      chk("IR", IR, m_ir);
      chk("MAR", MAR, m_mar);
      chk("MDR", MDR, m_mdr);
      chk("NZP", 16'(NZP), 16'(m_nzp));
      chk("Bus_Err", 16'(Bus_Err), 16'(m_err));
      chk("Mem_Req", 16'(Mem_Req), 16'(m_busy && !m_done));
      chk("Mem_Busy", 16'(Mem_Busy), 16'(m_busy));
      chk("Mem_Done", 16'(Mem_Done), 16'(m_done));
      chk("Mem_Wr", 16'(Mem_Wr), 16'(m_wr));
      chk("Mem_Addr", Mem_Addr, m_mar);
      chk("Mem_WData", Mem_WData, m_mdr);
    end
  end

  always @(negedge Clk) begin
    if (Mem_Req) req_cnt++;
    if (Mem_Done) done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic idle();
    LD_PC = 0; LD_IR = 0; LD_MAR = 0; LD_MDR = 0; LD_REG = 0; LD_CC = 0;
    GateALU = 0; GatePC = 0; GateMARMUX = 0; GateMDR = 0;
    PCMUX = 0; ADDR1MUX = 0; ADDR2MUX = 0; SR2MUX = 0; ALUK = 0;
    DR = 0; SR1 = 0; SR2 = 0;
    Mem_Start = 0; Mem_WE = 0; Mem_Rdy = 0; Mem_RData = 0;
  endtask

  task automatic mem_read(input logic [15:0] d, input int w);
    Mem_Start = 1; Mem_WE = 0;
    tick();
    Mem_Start = 0;
    repeat (w - 1) tick();
    Mem_Rdy = 1; Mem_RData = d;
    tick();
    Mem_Rdy = 0; Mem_RData = 0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, dc;
    idle();
    Reset_al = 0;
    run_chk = 1;
    tick(); tick();
    chk("rst_pc", PC, 16'h3000);
    chk("rst_nzp", 16'(NZP), 16'h0002);
    chk("rst_req", 16'(Mem_Req), 16'h0000);
    Reset_al = 1;
    tick();

    // PC+1 three times, then PCMUX=11 holds
    LD_PC = 1; PCMUX = 2'b00;
    tick(); tick(); tick();
    chk("pc_inc3", PC, 16'h3003);
    PCMUX = 2'b11;
    tick();
    chk("pc_hold", PC, 16'h3003);
    idle();

    // R1=0005, R2=FFFA via memory reads
    mem_read(16'h0005, 1);
    GateMDR = 1; LD_REG = 1; DR = 3'd1; tick(); idle();
    mem_read(16'hFFFA, 2);
    GateMDR = 1; LD_REG = 1; DR = 3'd2; tick(); idle();

    // R3 = R1 + R2 = FFFF
    SR1 = 3'd1; SR2 = 3'd2; ALUK = 2'b00; GateALU = 1; LD_REG = 1; DR = 3'd3; LD_CC = 1;
    tick(); idle();
    chk("add_nzp", 16'(NZP), 16'h0004);
    SR1 = 3'd3; ALUK = 2'b11; GateALU = 1; LD_MAR = 1;
    tick(); idle();
    chk("r3_pass", MAR, 16'hFFFF);
    SR1 = 3'd3; ALUK = 2'b10; GateALU = 1; LD_CC = 1; LD_MAR = 1;
    tick(); idle();
    chk("not_nzp", 16'(NZP), 16'h0002);
    chk("not_bus", MAR, 16'h0000);

    // PC wrap
    SR1 = 3'd3; ALUK = 2'b11; GateALU = 1; PCMUX = 2'b01; LD_PC = 1;
    tick(); idle();
    chk("pc_bus", PC, 16'hFFFF);
    PCMUX = 2'b00; LD_PC = 1;
    tick(); idle();
    chk("pc_wrap", PC, 16'h0000);

    // IR and address adder
    mem_read(16'h003F, 1);
    GateMDR = 1; LD_IR = 1; tick(); idle();
    chk("ir_load", IR, 16'h003F);
    ADDR1MUX = 0; ADDR2MUX = 2'b01; GateMARMUX = 1; LD_MAR = 1;
    tick(); idle();
    chk("adder_off6", MAR, 16'hFFFF);
    ADDR1MUX = 1; SR1 = 3'd1; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1;
    tick(); idle();
    chk("adder_off9", PC, 16'h0044);
    SR1 = 3'd1; SR2MUX = 1; ALUK = 2'b01; GateALU = 1; LD_CC = 1; LD_MAR = 1;
    tick(); idle();
    chk("and_imm", MAR, 16'h0005);
    chk("and_nzp", 16'(NZP), 16'h0001);

    // Read handshake with three REQ cycles, LD_MAR/LD_MDR ignored meanwhile
    mem_read(16'h0040, 1);
    GateMDR = 1; LD_MAR = 1; tick(); idle();
    chk("mar_0040", MAR, 16'h0040);
    rc = req_cnt; dc = done_cnt;
    Mem_Start = 1; tick(); Mem_Start = 0;
    GatePC = 1; LD_MAR = 1; LD_MDR = 1;
    tick(); tick();
    Mem_Rdy = 1; Mem_RData = 16'hBEEF;
    tick(); idle();
    Mem_Start = 1;  // lands in DONE, must be ignored
    tick(); idle();
    tick();
    chk("rd_mdr", MDR, 16'hBEEF);
    chk("rd_mar_stable", MAR, 16'h0040);
    chk("rd_req_cycles", 16'(req_cnt - rc), 16'd3);
    chk("rd_done_cycles", 16'(done_cnt - dc), 16'd1);
    chk("rd_start_ignored", 16'(Mem_Busy), 16'd0);

    // LD_MDR from bus, then a write aborted by reset
    SR1 = 3'd1; ALUK = 2'b11; GateALU = 1; LD_MDR = 1; tick(); idle();
    chk("mdr_bus", MDR, 16'h0005);
    mem_read(16'h1234, 1);
    dc = done_cnt;
    Mem_Start = 1; Mem_WE = 1; tick(); idle();
    chk("wr_wr", 16'(Mem_Wr), 16'd1);
    chk("wr_wdata", Mem_WData, 16'h1234);
    chk("wr_req", 16'(Mem_Req), 16'd1);
    tick();
    #2 Reset_al = 0;
    #1;
    chk("abort_req", 16'(Mem_Req), 16'd0);
    chk("abort_busy", 16'(Mem_Busy), 16'd0);
    chk("abort_mdr", MDR, 16'h0000);
    chk("abort_wr", 16'(Mem_Wr), 16'd0);
    tick(); tick();
    Reset_al = 1;
    tick(); tick(); tick();
    chk("abort_no_done", 16'(done_cnt - dc), 16'd0);
    chk("abort_pc", PC, 16'h3000);

    // Contention
    GatePC = 1; LD_MAR = 1; LD_CC = 1; tick(); idle();
    chk("pre_mar", MAR, 16'h3000);
    GatePC = 1; GateMDR = 1; LD_MAR = 1; LD_CC = 1; tick(); idle();
    chk("cont_bus", MAR, 16'h0000);
    chk("cont_nzp", 16'(NZP), 16'h0002);
    chk("cont_err", 16'(Bus_Err), 16'd1);
    repeat (10) tick();
    chk("cont_sticky", 16'(Bus_Err), 16'd1);
    Reset_al = 0; tick(); Reset_al = 1; tick();
    chk("err_cleared", 16'(Bus_Err), 16'd0);

    run_chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
